ecc_53_rd_pipe: RTL and testbench

ECC_53_RD_PIPE -- requirements
Module: ecc_53_rd_pipe

---
 rtl/ecc_53_rd_pipe.sv | 219 +++++++++++++++++++++
 tb/tb_ecc_53_rd_pipe.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_53_rd_pipe.sv
// ecc_53_rd_pipe: ECC read-data output stage.
// Two-entry register pipe (main + skid) for corrected read words.
// Each accepted word is classified as clean, single-bit or double-bit error.
// Saturating counters track single-bit and double-bit errors.
// A sticky capture holds the first error, and a double-bit error can upgrade it.
// irq is a registered level that stays high while a double-bit error is captured.
module ecc_53_rd_pipe #(
    parameter int DATA_WIDTH = 53,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_sbit_err,
    input  logic                  in_dbit_err,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            out_err,
    output logic [CNT_WIDTH-1:0]  sbit_cnt,
    output logic [CNT_WIDTH-1:0]  dbit_cnt,
    output logic                  err_valid,
    output logic [1:0]            err_type,
    output logic [ADDR_WIDTH-1:0] err_addr,
    input  logic                  err_clr,
    output logic                  irq
);

    localparam logic [1:0]           ERR_NONE = 2'b00;
    localparam logic [1:0]           ERR_SBIT = 2'b01;
    localparam logic [1:0]           ERR_DBIT = 2'b10;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Pipe registers
    logic                  r_inRdy;
    logic                  r_outVld;
    logic [DATA_WIDTH-1:0] r_outData;
    logic [1:0]            r_outErr;
    logic                  r_skidVld;
    logic [DATA_WIDTH-1:0] r_skidData;
    logic [1:0]            r_skidErr;

    // Error bookkeeping registers
    logic [CNT_WIDTH-1:0]  r_sbitCnt;
    logic [CNT_WIDTH-1:0]  r_dbitCnt;
    logic                  r_errValid;
    logic [1:0]            r_errType;
    logic [ADDR_WIDTH-1:0] r_errAddr;
    logic                  r_irq;

    // Combinational helpers
    logic                  w_accept;
    logic                  w_mainFree;
    logic                  w_skidVldNext;
    logic [1:0]            w_inErr;
    logic                  w_isSbit;
    logic                  w_isDbit;
    logic [CNT_WIDTH-1:0]  w_sbitBase;
    logic [CNT_WIDTH-1:0]  w_dbitBase;
    logic [CNT_WIDTH-1:0]  w_sbitNext;
    logic [CNT_WIDTH-1:0]  w_dbitNext;
    logic                  w_capValidBase;
    logic [1:0]            w_capTypeBase;
    logic [ADDR_WIDTH-1:0] w_capAddrBase;
    logic                  w_capValidNext;
    logic [1:0]            w_capTypeNext;
    logic [ADDR_WIDTH-1:0] w_capAddrNext;

    assign w_accept   = in_vld & r_inRdy;
    assign w_mainFree = ~r_outVld | out_rdy;

    // Classify the incoming word; double-bit wins over single-bit
    always_comb begin
        w_isDbit = in_dbit_err;
        w_isSbit = in_sbit_err & ~in_dbit_err;
        if (w_isDbit) begin
            w_inErr = ERR_DBIT;
        end else if (w_isSbit) begin
            w_inErr = ERR_SBIT;
        end else begin
            w_inErr = ERR_NONE;
        end
    end

    // Skid occupancy for next cycle: it drains whenever the main entry frees up
    always_comb begin
        w_skidVldNext = r_skidVld;
        if (w_mainFree) begin
            w_skidVldNext = 1'b0;
        end else if (w_accept) begin
            w_skidVldNext = 1'b1;
        end
    end

    // Main/skid data movement; the skid word takes priority for the output slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outVld   <= 1'b0;
            r_outData  <= '0;
            r_outErr   <= ERR_NONE;
            r_skidData <= '0;
            r_skidErr  <= ERR_NONE;
        end else begin
            if (w_mainFree) begin
                if (r_skidVld) begin
                    r_outVld  <= 1'b1;
                    r_outData <= r_skidData;
                    r_outErr  <= r_skidErr;
                end else if (w_accept) begin
                    r_outVld  <= 1'b1;
                    r_outData <= in_data;
                    r_outErr  <= w_inErr;
                end else begin
                    r_outVld  <= 1'b0;
                end
            end else if (w_accept) begin
                r_skidData <= in_data;
                r_skidErr  <= w_inErr;
            end
        end
    end

    // Skid valid and registered ready; ready stays low until the first edge after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skidVld <= 1'b0;
            r_inRdy   <= 1'b0;
        end else begin
            r_skidVld <= w_skidVldNext;
            r_inRdy   <= ~w_skidVldNext;
        end
    end

    // Counter next values: a clear is applied first, then the accepted word counts
    always_comb begin
        w_sbitBase = err_clr ? '0 : r_sbitCnt;
        w_dbitBase = err_clr ? '0 : r_dbitCnt;
        w_sbitNext = w_sbitBase;
        w_dbitNext = w_dbitBase;
        if (w_accept && w_isSbit && (w_sbitBase != CNT_MAX)) begin
            w_sbitNext = w_sbitBase + CNT_ONE;
        end
        if (w_accept && w_isDbit && (w_dbitBase != CNT_MAX)) begin
            w_dbitNext = w_dbitBase + CNT_ONE;
        end
    end

    // Saturating error counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sbitCnt <= '0;
            r_dbitCnt <= '0;
        end else begin
            r_sbitCnt <= w_sbitNext;
            r_dbitCnt <= w_dbitNext;
        end
    end

    // Capture next values: first error loads, a double-bit error upgrades a single-bit capture
    always_comb begin
        w_capValidBase = err_clr ? 1'b0 : r_errValid;
        w_capTypeBase  = err_clr ? ERR_NONE : r_errType;
        w_capAddrBase  = err_clr ? '0 : r_errAddr;
        w_capValidNext = w_capValidBase;
        w_capTypeNext  = w_capTypeBase;
        w_capAddrNext  = w_capAddrBase;
        if (w_accept && (w_isSbit || w_isDbit)) begin
            if (!w_capValidBase) begin
                w_capValidNext = 1'b1;
                w_capTypeNext  = w_inErr;
                w_capAddrNext  = in_addr;
            end else if ((w_capTypeBase == ERR_SBIT) && w_isDbit) begin
                w_capTypeNext  = ERR_DBIT;
                w_capAddrNext  = in_addr;
            end
        end
    end

    // Sticky error capture registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_errValid <= 1'b0;
            r_errType  <= ERR_NONE;
            r_errAddr  <= '0;
        end else begin
            r_errValid <= w_capValidNext;
            r_errType  <= w_capTypeNext;
            r_errAddr  <= w_capAddrNext;
        end
    end

    // Interrupt follows a captured double-bit error one cycle later; only clear or reset drops it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else if (err_clr) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (r_errType == ERR_DBIT);
        end
    end

    assign in_rdy    = r_inRdy;
    assign out_vld   = r_outVld;
    assign out_data  = r_outData;
    assign out_err   = r_outErr;
    assign sbit_cnt  = r_sbitCnt;
    assign dbit_cnt  = r_dbitCnt;
    assign err_valid = r_errValid;
    assign err_type  = r_errType;
    assign err_addr  = r_errAddr;
    assign irq       = r_irq;

endmodule

// File: tb/tb_ecc_53_rd_pipe.sv
// Testbench for ecc_53_rd_pipe.
// A scoreboard queues the expected word at each accept and compares it when the word leaves.
// Directed sequences cover streaming, backpressure, error capture, saturation and reset.
module tb_ecc_53_rd_pipe;

    localparam int DW = 53;
    localparam int AW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_vld = 1'b0;
    logic          in_rdy;
    logic [DW-1:0] in_data = '0;
    logic          in_sbit_err = 1'b0;
    logic          in_dbit_err = 1'b0;
    logic [AW-1:0] in_addr = '0;
    logic          out_vld;
    logic          out_rdy = 1'b1;
    logic [DW-1:0] out_data;
    logic [1:0]    out_err;
    logic [CW-1:0] sbit_cnt;
    logic [CW-1:0] dbit_cnt;
    logic          err_valid;
    logic [1:0]    err_type;
    logic [AW-1:0] err_addr;
    logic          err_clr = 1'b0;
    logic          irq;

    int checks = 0;
    int errors = 0;
    int cycleCount = 0;
    bit chkLat = 1'b0;
    logic [DW+1:0] expQ[$];
    int cycQ[$];
    logic [DW+1:0] heldWord = '0;
    bit holdValid = 1'b0;

    always #5 clk = ~clk;

    ecc_53_rd_pipe #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .in_data    (in_data),
        .in_sbit_err(in_sbit_err),
        .in_dbit_err(in_dbit_err),
        .in_addr    (in_addr),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .out_data   (out_data),
        .out_err    (out_err),
        .sbit_cnt   (sbit_cnt),
        .dbit_cnt   (dbit_cnt),
        .err_valid  (err_valid),
        .err_type   (err_type),
        .err_addr   (err_addr),
        .err_clr    (err_clr),
        .irq        (irq)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected status of a word from its decoder flags
    function automatic logic [1:0] expErr(input logic s, input logic d);
        if (d) return 2'b10;
        if (s) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [DW-1:0] randData();
        logic [63:0] tmp;
        tmp = {$urandom(), $urandom()};
        return tmp[DW-1:0];
    endfunction

    // Scoreboard monitor on the falling edge, where all signals are settled
    always @(negedge clk) begin
        logic [DW+1:0] e;
        int c;
        cycleCount++;
        if (!rst_n) begin
            holdValid = 1'b0;
        end else begin
            if (holdValid && out_vld)
                checkOutput("hold_stable", {10'b0, out_err, out_data}, {10'b0, heldWord});
            holdValid = out_vld && !out_rdy;
            heldWord  = {out_err, out_data};
            if (out_vld && out_rdy) begin
                if (expQ.size() == 0) begin
                    checkOutput("sb_underflow", 64'(expQ.size()), 64'd1);
                end else begin
                    e = expQ.pop_front();
                    c = cycQ.pop_front();
                    checkOutput("out_word", {10'b0, out_err, out_data}, {10'b0, e});
                    if (chkLat) checkOutput("latency", 64'(cycleCount - c), 64'd1);
                end
            end
            if (in_vld && in_rdy) begin
                expQ.push_back({expErr(in_sbit_err, in_dbit_err), in_data});
                cycQ.push_back(cycleCount);
            end
        end
    end

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    // Present one word and hold it until accepted; returns just after the accepting edge
    task automatic applyStimulus(input logic [DW-1:0] d, input logic s, input logic db,
                                 input logic [AW-1:0] a);
        int n;
        in_vld      = 1'b1;
        in_data     = d;
        in_sbit_err = s;
        in_dbit_err = db;
        in_addr     = a;
        n = 0;
        @(negedge clk);
        while (!in_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_rdy) checkOutput("accept_timeout", {63'b0, in_rdy}, 64'd1);
        @(posedge clk);
        #1;
        in_vld = 1'b0;
    endtask

    task automatic clearPulse();
        err_clr = 1'b1;
        waitCycle();
        err_clr = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] wordA;

        // Reset state
        #2;
        checkOutput("rst_out_vld", {63'b0, out_vld}, 64'd0);
        checkOutput("rst_out_data", {11'b0, out_data}, 64'd0);
        checkOutput("rst_out_err", {62'b0, out_err}, 64'd0);
        checkOutput("rst_in_rdy", {63'b0, in_rdy}, 64'd0);
        checkOutput("rst_sbit_cnt", {60'b0, sbit_cnt}, 64'd0);
        checkOutput("rst_err_valid", {63'b0, err_valid}, 64'd0);
        checkOutput("rst_irq", {63'b0, irq}, 64'd0);
        waitCycle();
        rst_n = 1'b1;
        waitCycle();
        checkOutput("rdy_after_reset", {63'b0, in_rdy}, 64'd1);

        // Streaming: ten clean words, one-cycle latency, ready never drops
        $display("[TB] streaming");
        chkLat = 1'b1;
        out_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checkOutput("stream_rdy", {63'b0, in_rdy}, 64'd1);
            applyStimulus(randData(), 1'b0, 1'b0, AW'(i));
        end
        repeat (3) waitCycle();
        chkLat = 1'b0;
        checkOutput("stream_drained", 64'(expQ.size()), 64'd0);

        // Backpressure: two words held, third waits, then everything drains in order
        $display("[TB] backpressure");
        out_rdy = 1'b0;
        wordA = randData();
        applyStimulus(wordA, 1'b0, 1'b0, 8'h30);
        applyStimulus(randData(), 1'b0, 1'b0, 8'h31);
        checkOutput("bp_rdy_low", {63'b0, in_rdy}, 64'd0);
        checkOutput("bp_hold_data", {11'b0, out_data}, {11'b0, wordA});
        in_vld  = 1'b1;
        in_data = randData();
        in_addr = 8'h32;
        waitCycle();
        checkOutput("bp_rdy_still_low", {63'b0, in_rdy}, 64'd0);
        checkOutput("bp_hold_data2", {11'b0, out_data}, {11'b0, wordA});
        out_rdy = 1'b1;
        applyStimulus(in_data, 1'b0, 1'b0, 8'h32);
        repeat (4) waitCycle();
        checkOutput("bp_drained", 64'(expQ.size()), 64'd0);

        // Error capture: sbit, sbit, dbit
        $display("[TB] error capture");
        clearPulse();
        applyStimulus(randData(), 1'b1, 1'b0, 8'h05);
        checkOutput("cap1_addr", {56'b0, err_addr}, 64'h05);
        checkOutput("cap1_type", {62'b0, err_type}, 64'd1);
        checkOutput("cap1_valid", {63'b0, err_valid}, 64'd1);
        applyStimulus(randData(), 1'b1, 1'b0, 8'h07);
        checkOutput("cap2_addr", {56'b0, err_addr}, 64'h05);
        applyStimulus(randData(), 1'b0, 1'b1, 8'h09);
        checkOutput("cap3_addr", {56'b0, err_addr}, 64'h09);
        checkOutput("cap3_type", {62'b0, err_type}, 64'd2);
        checkOutput("irq_not_yet", {63'b0, irq}, 64'd0);
        waitCycle();
        checkOutput("irq_set", {63'b0, irq}, 64'd1);
        checkOutput("cnt_sbit", {60'b0, sbit_cnt}, 64'd2);
        checkOutput("cnt_dbit", {60'b0, dbit_cnt}, 64'd1);
        applyStimulus(randData(), 1'b1, 1'b0, 8'h0A);
        checkOutput("cap_locked_addr", {56'b0, err_addr}, 64'h09);
        checkOutput("cap_locked_type", {62'b0, err_type}, 64'd2);
        checkOutput("irq_held", {63'b0, irq}, 64'd1);

        // Both flags set: counted as double-bit only
        $display("[TB] both flags");
        clearPulse();
        checkOutput("clr_sbit", {60'b0, sbit_cnt}, 64'd0);
        checkOutput("clr_dbit", {60'b0, dbit_cnt}, 64'd0);
        checkOutput("clr_valid", {63'b0, err_valid}, 64'd0);
        checkOutput("clr_irq", {63'b0, irq}, 64'd0);
        applyStimulus(randData(), 1'b1, 1'b1, 8'h11);
        waitCycle();
        checkOutput("both_dbit", {60'b0, dbit_cnt}, 64'd1);
        checkOutput("both_sbit", {60'b0, sbit_cnt}, 64'd0);
        checkOutput("both_addr", {56'b0, err_addr}, 64'h11);

        // Saturation of the 4-bit counter, then clear with a simultaneous error word
        $display("[TB] saturation");
        clearPulse();
        for (int i = 0; i < 17; i++) begin
            applyStimulus(randData(), 1'b1, 1'b0, AW'(8'h40 + i));
            checkOutput("sat_count", {60'b0, sbit_cnt}, (i + 1 > 15) ? 64'd15 : 64'(i + 1));
        end
        err_clr = 1'b1;
        applyStimulus(randData(), 1'b1, 1'b0, 8'h22);
        err_clr = 1'b0;
        checkOutput("clr_hit_sbit", {60'b0, sbit_cnt}, 64'd1);
        checkOutput("clr_hit_addr", {56'b0, err_addr}, 64'h22);
        checkOutput("clr_hit_type", {62'b0, err_type}, 64'd1);
        checkOutput("clr_hit_dbit", {60'b0, dbit_cnt}, 64'd0);

        // Flags without an accept are ignored
        in_sbit_err = 1'b1;
        in_dbit_err = 1'b1;
        repeat (2) waitCycle();
        checkOutput("idle_sbit", {60'b0, sbit_cnt}, 64'd1);
        checkOutput("idle_dbit", {60'b0, dbit_cnt}, 64'd0);
        checkOutput("idle_type", {62'b0, err_type}, 64'd1);
        in_sbit_err = 1'b0;
        in_dbit_err = 1'b0;
        repeat (3) waitCycle();
        checkOutput("pre_reset_drained", 64'(expQ.size()), 64'd0);

        // Reset with both entries full
        $display("[TB] reset mid-transfer");
        out_rdy = 1'b0;
        applyStimulus(randData(), 1'b0, 1'b0, 8'h50);
        applyStimulus(randData(), 1'b0, 1'b0, 8'h51);
        checkOutput("full_rdy_low", {63'b0, in_rdy}, 64'd0);
        rst_n = 1'b0;
        #1;
        expQ.delete();
        cycQ.delete();
        checkOutput("mid_rst_out_vld", {63'b0, out_vld}, 64'd0);
        checkOutput("mid_rst_out_data", {11'b0, out_data}, 64'd0);
        checkOutput("mid_rst_in_rdy", {63'b0, in_rdy}, 64'd0);
        checkOutput("mid_rst_sbit", {60'b0, sbit_cnt}, 64'd0);
        checkOutput("mid_rst_valid", {63'b0, err_valid}, 64'd0);
        checkOutput("mid_rst_type", {62'b0, err_type}, 64'd0);
        checkOutput("mid_rst_addr", {56'b0, err_addr}, 64'd0);
        waitCycle();
        rst_n = 1'b1;
        waitCycle();
        checkOutput("post_rst_rdy", {63'b0, in_rdy}, 64'd1);
        out_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("post_rst_no_word", {63'b0, out_vld}, 64'd0);
            waitCycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
